// File: rtl/mar_dump_unit_if.sv
// Dump beat stream: {dump_addr, dump_data} offered by the MAR dump sequencer under valid/ready.
`timescale 1ns/1ps
interface mar_dump_unit_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;

    modport master (output dump_valid, output dump_addr, output dump_data, input dump_ready);
    modport slave  (input dump_valid, input dump_addr, input dump_data, output dump_ready);
endinterface

// File: rtl/mar_dump_unit.sv
// Memory address register with a debug dump sequencer that walks RAM[DUMP_FIRST..DUMP_LAST].
// Optional running byte checksum of the dump is enabled by defining DUMP_CKSUM_EN.
`timescale 1ns/1ps
module mar_dump_unit #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int DUMP_FIRST = 0,
    parameter int DUMP_LAST  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              LM,
    output logic [ADDR_W-1:0] address,
    output logic              ram_ce,
    input  logic [DATA_W-1:0] ram_data,
    input  logic              dump_start,
    output logic              busy,
    mar_dump_unit_if.master   dump
`ifdef DUMP_CKSUM_EN
    ,
    output logic [DATA_W-1:0] dump_cksum,
    output logic              cksum_valid
`endif
);
    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(DUMP_FIRST);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DUMP_LAST);

    if (DUMP_LAST < DUMP_FIRST) begin : g_bad_range
        $error("mar_dump_unit: DUMP_LAST must be >= DUMP_FIRST");
    end
    if (DUMP_LAST >= (1 << ADDR_W) || DUMP_FIRST < 0) begin : g_bad_addr
        $error("mar_dump_unit: dump range outside RAM");
    end

    // Only the low nibble of the bus addresses the RAM.
    if (DATA_W > ADDR_W) begin : g_unused
        logic unused_bus_hi;
        assign unused_bus_hi = ^bus_in[DATA_W-1:ADDR_W];
    end

    typedef enum logic [1:0] {IDLE, ADDR, HOLD, RESTORE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] saved_mar;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            address         <= '0;
            saved_mar       <= '0;
            ram_ce          <= 1'b0;
            busy            <= 1'b0;
            dump.dump_valid <= 1'b0;
            dump.dump_addr  <= '0;
            dump.dump_data  <= '0;
`ifdef DUMP_CKSUM_EN
            dump_cksum      <= '0;
            cksum_valid     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // dump_start outranks LM, so the saved value is the pre-edge address
                    if (dump_start) begin
                        saved_mar <= address;
                        address   <= FIRST_A;
                        ram_ce    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ADDR;
`ifdef DUMP_CKSUM_EN
                        dump_cksum <= '0;
`endif
                    end else if (LM) begin
                        address <= bus_in[ADDR_W-1:0];
                    end
                end
                ADDR: begin
                    ram_ce          <= 1'b0;
                    dump.dump_data  <= ram_data;
                    dump.dump_addr  <= address;
                    dump.dump_valid <= 1'b1;
                    state           <= HOLD;
`ifdef DUMP_CKSUM_EN
                    dump_cksum      <= dump_cksum + ram_data;
`endif
                end
                HOLD: begin
                    if (dump.dump_valid && dump.dump_ready) begin
                        dump.dump_valid <= 1'b0;
                        if (address == LAST_A) begin
                            state <= RESTORE;
`ifdef DUMP_CKSUM_EN
                            cksum_valid <= 1'b1;
`endif
                        end else begin
                            address <= address + ADDR_W'(1);
                            ram_ce  <= 1'b1;
                            state   <= ADDR;
                        end
                    end
                end
                RESTORE: begin
                    address <= saved_mar;
                    busy    <= 1'b0;
                    state   <= IDLE;
`ifdef DUMP_CKSUM_EN
                    cksum_valid <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mar_dump_unit.sv
// Scoreboard bench for mar_dump_unit: RAM model, expected-beat queues and decoupled monitors.
`timescale 1ns/1ps
module tb_mar_dump_unit;
    localparam int AW = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] bus_in;
    logic          LM, dump_start;
    logic [AW-1:0] address;
    logic          ram_ce, busy;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] mem [16];

    logic [DW-1:0] bus_in2;
    logic          lm2, start2;
    logic [AW-1:0] address2;
    logic          ram_ce2, busy2;
    logic [DW-1:0] ram_data2;

    mar_dump_unit_if #(.ADDR_W(AW), .DATA_W(DW)) dif ();
    mar_dump_unit_if #(.ADDR_W(AW), .DATA_W(DW)) dif2 ();

    assign ram_data  = ram_ce  ? mem[address]  : '0;
    assign ram_data2 = ram_ce2 ? mem[address2] : '0;

`ifdef DUMP_CKSUM_EN
    logic [DW-1:0] dump_cksum, dump_cksum2;
    logic          cksum_valid, cksum_valid2;
`endif

    mar_dump_unit #(.ADDR_W(AW), .DATA_W(DW), .DUMP_FIRST(0), .DUMP_LAST(15)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .LM(LM), .address(address), .ram_ce(ram_ce),
        .ram_data(ram_data), .dump_start(dump_start), .busy(busy), .dump(dif.master)
`ifdef DUMP_CKSUM_EN
        , .dump_cksum(dump_cksum), .cksum_valid(cksum_valid)
`endif
    );

    mar_dump_unit #(.ADDR_W(AW), .DATA_W(DW), .DUMP_FIRST(8), .DUMP_LAST(10)) dut2 (
        .clk(clk), .rst(rst), .bus_in(bus_in2), .LM(lm2), .address(address2), .ram_ce(ram_ce2),
        .ram_data(ram_data2), .dump_start(start2), .busy(busy2), .dump(dif2.master)
`ifdef DUMP_CKSUM_EN
        , .dump_cksum(dump_cksum2), .cksum_valid(cksum_valid2)
`endif
    );

    int    n_chk = 0;
    int    n_fail = 0;
    beat_t q[$];
    beat_t q2[$];
    int    ready_mode = 0;
    int    ck_pulses = 0;
    logic [DW-1:0] ck_seen = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Consumer ready pattern for the main instance.
    initial begin : ready_drv
        int cyc = 0;
        dif.dump_ready = 1'b1;
        dif2.dump_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            case (ready_mode)
                0: dif.dump_ready = 1'b1;
                1: dif.dump_ready = ((cyc / 3) % 2) == 0;
                default: dif.dump_ready = 1'($urandom % 2);
            endcase
        end
    end

    // Main monitor: pops expected beats on acceptance, checks stability while stalled.
    initial begin : mon1
        logic stall = 1'b0;
        logic [AW-1:0] ha = '0;
        logic [DW-1:0] hd = '0;
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst) stall = 1'b0;
            else begin
                if (stall) begin
                    check("hold_valid", dif.dump_valid, 1);
                    check("hold_addr", dif.dump_addr, ha);
                    check("hold_data", dif.dump_data, hd);
                end
                if (dif.dump_valid && dif.dump_ready) begin
                    if (q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL extra_beat: got beat %0h:%0h expected none", dif.dump_addr, dif.dump_data);
                    end else begin
                        e = q.pop_front();
                        check("beat_addr", dif.dump_addr, e.a);
                        check("beat_data", dif.dump_data, e.d);
                    end
                end
                if (ram_ce) check("ce_only_in_addr", {busy, dif.dump_valid}, 2'b10);
`ifdef DUMP_CKSUM_EN
                if (cksum_valid) begin
                    ck_pulses++;
                    ck_seen = dump_cksum;
                end
`endif
                stall = dif.dump_valid && !dif.dump_ready;
                ha = dif.dump_addr;
                hd = dif.dump_data;
            end
        end
    end

    initial begin : mon2
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst && dif2.dump_valid && dif2.dump_ready) begin
                if (q2.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL extra_beat2: got beat %0h:%0h expected none", dif2.dump_addr, dif2.dump_data);
                end else begin
                    e = q2.pop_front();
                    check("beat2_addr", dif2.dump_addr, e.a);
                    check("beat2_data", dif2.dump_data, e.d);
                end
            end
        end
    end

    // Reference: a dump is every RAM byte in range, in address order, then the old MAR comes back.
    task automatic do_dump(input logic [AW-1:0] start_addr, input logic use_lm, input logic same_lm,
                           input logic noise, input logic chk_len);
        int len = 0;
        logic [DW-1:0] sum = '0;
        if (use_lm) begin
            LM = 1'b1;
            bus_in = {4'($urandom), start_addr};
            @(posedge clk); #1;
            LM = 1'b0;
            check("lm_load", address, start_addr);
        end
        for (int a = 0; a < 16; a++) begin
            q.push_back('{a: AW'(a), d: mem[a]});
            sum = sum + mem[a];
        end
        ck_pulses = 0;
        dump_start = 1'b1;
        LM = same_lm;
        bus_in = same_lm ? 8'h07 : 8'($urandom);
        @(posedge clk); #1;
        dump_start = 1'b0;
        LM = 1'b0;
        while (busy && len < 400) begin
            len++;
            if (noise) begin
                LM = 1'($urandom % 2);
                bus_in = 8'($urandom);
                dump_start = 1'($urandom % 2);
            end
            @(posedge clk); #1;
        end
        LM = 1'b0;
        dump_start = 1'b0;
        if (len >= 400) begin
            n_chk++; n_fail++;
            $display("FAIL dump_timeout: busy still high after %0d cycles", len);
        end
        check("restore_addr", address, start_addr);
        if (chk_len) check("busy_len", len, 33);
        check("beats_left", q.size(), 0);
        q.delete();
`ifdef DUMP_CKSUM_EN
        check("cksum_pulses", ck_pulses, 1);
        check("cksum_at_pulse", ck_seen, sum);
        check("cksum_hold", dump_cksum, sum);
`endif
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int len;
        rst = 1'b1; LM = 1'b0; dump_start = 1'b0; bus_in = '0;
        lm2 = 1'b0; start2 = 1'b0; bus_in2 = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = 8'h08; mem[1] = 8'h19; mem[2] = 8'h2A; mem[3] = 8'hE0;
        mem[8] = 8'h06; mem[9] = 8'h05; mem[10] = 8'h02;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_address", address, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", dif.dump_valid, 0);
        check("rst_ce", ram_ce, 0);
        check("rst_daddr", dif.dump_addr, 0);
        check("rst_ddata", dif.dump_data, 0);
`ifdef DUMP_CKSUM_EN
        check("rst_cksum", {cksum_valid, dump_cksum}, 0);
`endif
        LM = 1'b1; bus_in = 8'h3A;
        @(posedge clk); #1;
        LM = 1'b0;
        check("lm_3a", address, 4'hA);

        ready_mode = 0;
        do_dump(4'h5, 1'b1, 1'b0, 1'b0, 1'b1);
        ready_mode = 1;
        do_dump(4'h9, 1'b1, 1'b0, 1'b0, 1'b0);
        ready_mode = 0;
        do_dump(4'h2, 1'b1, 1'b1, 1'b1, 1'b1);

        // Reset while beat 5 is being offered.
        LM = 1'b1; bus_in = 8'h03;
        @(posedge clk); #1;
        LM = 1'b0;
        for (int a = 0; a < 16; a++) q.push_back('{a: AW'(a), d: mem[a]});
        dump_start = 1'b1;
        @(posedge clk); #1;
        dump_start = 1'b0;
        len = 0;
        while (!(dif.dump_valid && dif.dump_addr == 4'h5) && len < 100) begin
            len++;
            @(posedge clk); #1;
        end
        check("reached_beat5", dif.dump_addr, 4'h5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        check("mid_rst_address", address, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", dif.dump_valid, 0);
        check("mid_rst_ce", ram_ce, 0);
        do_dump(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Narrow-range instance.
        for (int a = 8; a <= 10; a++) q2.push_back('{a: AW'(a), d: mem[a]});
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        len = 0;
        while (busy2 && len < 100) begin
            len++;
            @(posedge clk); #1;
        end
        check("narrow_busy_len", len, 7);
        check("narrow_beats_left", q2.size(), 0);
        check("narrow_restore", address2, 0);

        // Random RAM contents, random backpressure and input noise while busy.
        ready_mode = 2;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            do_dump(4'($urandom), 1'b1, 1'($urandom % 2), 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
